// File: rtl/reg_file_defs.sv
// Shared constants for the reg_file_bypass register bank and its busy scoreboard.
package reg_file_defs;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned ZERO_ADDR = 0;

    localparam bit BYPASS_OFF   = 1'b0;
    localparam bit BYPASS_ON    = 1'b1;
    localparam bit ZERO_REG_OFF = 1'b0;
    localparam bit ZERO_REG_ON  = 1'b1;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy scoreboard: one pending-producer bit per register, set on issue, cleared on writeback.
module reg_file_scoreboard
    import reg_file_defs::*;
#(
    parameter int unsigned mem_depth  = NUM_REGS,
    parameter int unsigned addr_width = $clog2(mem_depth),
    parameter int unsigned num_rd     = 2,
    parameter bit          zero_reg   = ZERO_REG_ON,
    parameter bit          bypass     = BYPASS_ON
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [addr_width-1:0]        w_addr,
    input  logic                         mark_en,
    input  logic [addr_width-1:0]        mark_addr,
    input  logic [num_rd*addr_width-1:0] rd_addr,
    output logic [num_rd-1:0]            rd_busy
);
    logic [mem_depth-1:0] busy_q, busy_d;
    logic                 w_valid, m_valid;

    function automatic logic addr_live(input logic [addr_width-1:0] a);
        return addr_in_range(32'(a), mem_depth) &&
               !(zero_reg == ZERO_REG_ON && a == addr_width'(ZERO_ADDR));
    endfunction

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        w_valid = we && addr_live(w_addr);
        m_valid = mark_en && addr_live(mark_addr);
        busy_d  = busy_q;
        if (w_valid) busy_d[w_addr] = 1'b0;
        if (m_valid) busy_d[mark_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < num_rd; i++) begin : g_port
        logic [addr_width-1:0] ra;
        logic                  fwd;
        assign ra         = rd_addr[i*addr_width +: addr_width];
        assign fwd        = (bypass == BYPASS_ON) && we && (w_addr == ra);
        assign rd_busy[i] = addr_live(ra) && !fwd && busy_q[ra];
    end
endmodule

// File: rtl/reg_file_bypass.sv
// Multi-read-port register bank with binary write address, optional x0 and write-to-read bypass.
module reg_file_bypass
    import reg_file_defs::*;
#(
    parameter int unsigned mem_width  = XLEN,
    parameter int unsigned mem_depth  = NUM_REGS,
    parameter int unsigned addr_width = $clog2(mem_depth),
    parameter int unsigned num_rd     = 2,
    parameter bit          zero_reg   = ZERO_REG_ON,
    parameter bit          bypass     = BYPASS_ON
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [addr_width-1:0]          w_addr,
    input  logic [mem_width-1:0]           w_data,
    input  logic [num_rd*addr_width-1:0]   rd_addr,
    output logic [num_rd*mem_width-1:0]    rd_data,
    output logic [num_rd-1:0]              rd_busy,
    input  logic                           mark_en,
    input  logic [addr_width-1:0]          mark_addr,
    output logic [mem_width*mem_depth-1:0] Rout
);
    localparam bit fwd_en  = (bypass != BYPASS_OFF);
    localparam bit zero_en = (zero_reg != ZERO_REG_OFF);

    logic [mem_width-1:0] regs_q [mem_depth];
    logic [mem_width-1:0] regs_d [mem_depth];

    function automatic logic addr_live(input logic [addr_width-1:0] a);
        return addr_in_range(32'(a), mem_depth) && !(zero_en && a == addr_width'(ZERO_ADDR));
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (we && addr_live(w_addr)) regs_d[w_addr] = w_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < num_rd; i++) begin : g_rd
        logic [addr_width-1:0] ra;
        assign ra = rd_addr[i*addr_width +: addr_width];
        assign rd_data[i*mem_width +: mem_width] =
            !addr_live(ra)                 ? '0     :
            (fwd_en && we && w_addr == ra) ? w_data :
                                             regs_q[ra];
    end

    for (genvar i = 0; i < mem_depth; i++) begin : g_rout
        if (zero_en && i == int'(ZERO_ADDR)) begin : g_zero
            assign Rout[i*mem_width +: mem_width] = '0;
        end else begin : g_reg
            assign Rout[i*mem_width +: mem_width] = regs_q[i];
        end
    end

    reg_file_scoreboard #(
        .mem_depth  (mem_depth),
        .addr_width (addr_width),
        .num_rd     (num_rd),
        .zero_reg   (zero_reg),
        .bypass     (bypass)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .w_addr    (w_addr),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy)
    );
endmodule
